// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Purpose  : Instruction-fetch stage of the RV32I pipeline. Owns the PC,
//            issues word fetches over a req/gnt + rvalid memory interface,
//            buffers returned words with their PCs in a small queue and hands
//            them to decode under a valid/ready handshake. Redirects from EX
//            flush the queue and discard stale in-flight responses.
// Ports    : clk, rst            - clock, async active-high reset
//            imem_req/addr/gnt   - fetch request channel
//            imem_rvalid/rdata   - in-order fetch response channel
//            redirect/redirect_pc- control-flow change from EX
//            id_ready            - decode can accept
//            if_valid/instr/pc/pc4 - IF/ID boundary outputs
// Revision : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4
);

  localparam int              CW        = $clog2(DEPTH + 1);
  localparam int              PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]     C_DEPTH   = (CW + 1)'(DEPTH);
  localparam logic [31:0]     C_NOP     = 32'h0000_0013;
  localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(4);

  // Architectural state
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   disc_cnt;
  logic [XLEN-1:0] last_pc;

  // Instruction queue
  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;

  logic            credit_ok;
  logic            grant;
  logic            pop;
  logic            keep;
  logic            drop;
  logic [XLEN-1:0] target_pc;
  logic            unused_bits;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Low address bits of the target are ignored; instructions are word aligned.
  assign target_pc   = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_bits = ^redirect_pc[1:0];

  // Credit counts outstanding requests plus queued words, so every granted
  // request is guaranteed a queue slot when it returns. A pop in the same
  // cycle is deliberately not credited to keep this path short.
  assign credit_ok = ({1'b0, out_cnt} + {1'b0, count}) < C_DEPTH;
  assign imem_req  = !rst && !redirect && credit_ok;
  assign imem_addr = pc_q;
  assign grant     = imem_req && imem_gnt;

  assign if_valid  = (count != '0);
  assign pop       = if_valid && id_ready && !redirect;
  assign keep      = imem_rvalid && !redirect && (disc_cnt == '0);
  assign drop      = imem_rvalid && !redirect && (disc_cnt != '0);

  // When empty, decode sees a NOP while the PC outputs keep the last
  // delivered address.
  always_comb begin
    if_instr = C_NOP;
    if_pc    = last_pc;
    if (if_valid) begin
      if_instr = q_instr[head];
      if_pc    = q_pc[head];
    end
    if_pc4 = if_pc + C_PC_STEP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_cnt   <= '0;
      disc_cnt  <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      last_pc   <= '0;
    end else if (redirect) begin
      pc_q      <= target_pc;
      resp_pc_q <= target_pc;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      // Everything still in flight is stale, including words already owed
      // to an earlier discard; a response arriving now is dropped as well.
      out_cnt   <= out_cnt - CW'(imem_rvalid);
      disc_cnt  <= out_cnt - CW'(imem_rvalid);
    end else begin
      if (grant) begin
        pc_q <= pc_q + C_PC_STEP;
      end
      out_cnt <= out_cnt + CW'(grant) - CW'(imem_rvalid);
      if (drop) begin
        disc_cnt <= disc_cnt - CW'(1);
      end
      if (keep) begin
        resp_pc_q <= resp_pc_q + C_PC_STEP;
        tail      <= ptr_inc(tail);
      end
      if (pop) begin
        head    <= ptr_inc(head);
        last_pc <= q_pc[head];
      end
      count <= count + CW'(keep) - CW'(pop);
    end
  end

  // Queue payload needs no reset: it is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (keep) begin
      q_instr[tail] <= imem_rdata;
      q_pc[tail]    <= resp_pc_q;
    end
  end

  // Protocol check: a response must always match an outstanding request.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && (out_cnt == '0)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Purpose  : Directed self-checking bench for fetch_stage with an in-order,
//            fixed-latency instruction memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk         = 1'b0;
  logic        rst         = 1'b1;
  logic        imem_gnt    = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready    = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;

  int          n_checks = 0;
  int          n_fails  = 0;
  int          cyc      = 0;
  int          lat      = 1;
  logic [31:0] exp_pc   = '0;
  logic [31:0] q_addr [$];
  int          q_due  [$];

  fetch_stage #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000),
    .DEPTH   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_ready   (id_ready),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc4     (if_pc4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a | 32'hA500_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_resp();
    if (q_addr.size() > 0 && q_due[0] == cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(q_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  endtask

  // One clock: check any delivered word against the expected PC stream,
  // advance the memory model, then present this cycle's response.
  task automatic cycle();
    logic        s_req;
    logic        s_gnt;
    logic        s_rv;
    logic [31:0] s_addr;
    s_req  = imem_req;
    s_gnt  = imem_gnt;
    s_rv   = imem_rvalid;
    s_addr = imem_addr;
    if (if_valid && id_ready && !redirect) begin
      chk("stream_pc", if_pc, exp_pc);
      chk("stream_instr", if_instr, mem_word(exp_pc));
      chk("stream_pc4", if_pc4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (s_rv) begin
      void'(q_addr.pop_front());
      void'(q_due.pop_front());
    end
    if (s_req && s_gnt) begin
      q_addr.push_back(s_addr);
      q_due.push_back(cyc - 1 + lat);
    end
    drive_resp();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, NOP);
    chk("rst_pc",    if_pc, 32'h0);
    chk("rst_pc4",   if_pc4, 32'h4);

    // Basic streaming, latency 1
    rst = 1'b0; cyc = 0; lat = 1; imem_gnt = 1'b1; id_ready = 1'b1; #1;
    chk("c0_req", 32'(imem_req), 32'd1); chk("c0_addr", imem_addr, 32'h0);
    chk("c0_valid", 32'(if_valid), 32'd0); cycle();
    chk("c1_req", 32'(imem_req), 32'd1); chk("c1_addr", imem_addr, 32'h4);
    chk("c1_valid", 32'(if_valid), 32'd0); cycle();
    chk("c2_req", 32'(imem_req), 32'd0); chk("c2_valid", 32'(if_valid), 32'd1);
    chk("c2_pc", if_pc, 32'h0); cycle();
    chk("c3_addr", imem_addr, 32'h8); chk("c3_pc", if_pc, 32'h4); cycle();
    chk("c4_addr", imem_addr, 32'hC); chk("c4_valid", 32'(if_valid), 32'd0); cycle();
    chk("c5_req", 32'(imem_req), 32'd0); chk("c5_pc", if_pc, 32'h8); cycle();

    // Grant withheld: address must hold
    imem_gnt = 1'b0; #1;
    chk("gnt0_c6_req", 32'(imem_req), 32'd1); chk("gnt0_c6_addr", imem_addr, 32'h10); cycle();
    chk("gnt0_c7_addr", imem_addr, 32'h10); chk("gnt0_c7_valid", 32'(if_valid), 32'd0); cycle();
    chk("gnt0_c8_addr", imem_addr, 32'h10); cycle();
    imem_gnt = 1'b1; #1;
    chk("gnt1_c9_addr", imem_addr, 32'h10); cycle();
    chk("gnt1_c10_addr", imem_addr, 32'h14); cycle();

    // Decode stall for 6 cycles: queue fills, requests stop, outputs hold
    id_ready = 1'b0; #1;
    chk("stall_c11_req", 32'(imem_req), 32'd0); chk("stall_c11_pc", if_pc, 32'h10);
    repeat (5) cycle();
    chk("stall_c16_req", 32'(imem_req), 32'd0); chk("stall_c16_valid", 32'(if_valid), 32'd1);
    chk("stall_c16_pc", if_pc, 32'h10); chk("stall_c16_instr", if_instr, mem_word(32'h10));
    cycle();
    id_ready = 1'b1; #1;
    chk("rel_c17_pc", if_pc, 32'h10); cycle();
    chk("rel_c18_addr", imem_addr, 32'h18); chk("rel_c18_pc", if_pc, 32'h14); cycle();
    chk("rel_c19_addr", imem_addr, 32'h1C); chk("rel_c19_valid", 32'(if_valid), 32'd0); cycle();
    chk("rel_c20_req", 32'(imem_req), 32'd0); chk("rel_c20_pc", if_pc, 32'h18); cycle();

    // Latency 2, redirect with two requests outstanding
    lat = 2; #1;
    chk("l2_c21_addr", imem_addr, 32'h20); chk("l2_c21_pc", if_pc, 32'h1C); cycle();
    chk("l2_c22_addr", imem_addr, 32'h24); chk("l2_c22_valid", 32'(if_valid), 32'd0); cycle();
    redirect = 1'b1; redirect_pc = 32'h0000_0103; exp_pc = 32'h100; #1;
    chk("redir1_req", 32'(imem_req), 32'd0); cycle();
    redirect = 1'b0; #1;
    chk("redir1_addr", imem_addr, 32'h100); chk("redir1_req_on", 32'(imem_req), 32'd1); cycle();
    chk("c25_addr", imem_addr, 32'h104); chk("c25_valid", 32'(if_valid), 32'd0); cycle();
    chk("c26_req", 32'(imem_req), 32'd0); chk("c26_valid", 32'(if_valid), 32'd0); cycle();
    chk("c27_valid", 32'(if_valid), 32'd1); chk("c27_pc", if_pc, 32'h100);
    chk("c27_instr", if_instr, mem_word(32'h100)); cycle();
    chk("c28_addr", imem_addr, 32'h108); chk("c28_pc", if_pc, 32'h104); cycle();
    chk("c29_addr", imem_addr, 32'h10C); chk("c29_valid", 32'(if_valid), 32'd0); cycle();
    chk("c30_req", 32'(imem_req), 32'd0); chk("c30_valid", 32'(if_valid), 32'd0); cycle();

    // Redirect coinciding with rvalid, id_ready and a valid head word
    chk("c31_valid", 32'(if_valid), 32'd1); chk("c31_pc", if_pc, 32'h108);
    redirect = 1'b1; redirect_pc = 32'h0000_0200; exp_pc = 32'h200; #1;
    chk("redir2_req", 32'(imem_req), 32'd0); cycle();
    redirect = 1'b0; #1;
    chk("redir2_valid", 32'(if_valid), 32'd0); chk("redir2_instr", if_instr, NOP);
    chk("redir2_pc_hold", if_pc, 32'h104); chk("redir2_pc4_hold", if_pc4, 32'h108);
    chk("redir2_addr", imem_addr, 32'h200); cycle();
    chk("c33_addr", imem_addr, 32'h204); cycle();
    chk("c34_req", 32'(imem_req), 32'd0); chk("c34_valid", 32'(if_valid), 32'd0); cycle();
    chk("c35_pc", if_pc, 32'h200); chk("c35_instr", if_instr, mem_word(32'h200)); cycle();
    chk("c36_pc", if_pc, 32'h204); chk("c36_valid", 32'(if_valid), 32'd1);

    // Asynchronous reset mid-stream; memory is reset alongside
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(if_valid), 32'd0); chk("arst_instr", if_instr, NOP);
    chk("arst_req", 32'(imem_req), 32'd0); chk("arst_pc", if_pc, 32'h0);
    q_addr.delete(); q_due.delete(); imem_rvalid = 1'b0; imem_rdata = '0; lat = 1;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("post_rst_req", 32'(imem_req), 32'd1); chk("post_rst_addr", imem_addr, 32'h0);
    chk("post_rst_valid", 32'(if_valid), 32'd0);

    // PC wrap-around at 2^32
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE; exp_pc = 32'hFFFF_FFFC; #1;
    chk("wrap_redir_req", 32'(imem_req), 32'd0); cycle();
    redirect = 1'b0; #1;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC); cycle();
    chk("wrap_addr1", imem_addr, 32'h0); chk("wrap_req1", 32'(imem_req), 32'd1); cycle();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC); chk("wrap_pc4", if_pc4, 32'h0);
    repeat (6) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
